data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-port data memory between two requesters: the CPU operate core (port 0) and a debug/loader host port (port 1). One access is granted per cycle; reads return one cycle later, matching the memory's registered read. Fixed priority with starvation protection is the default; round-robin is a compile-time option. It sits between the requesters and the data memory, upstream of the memory-mapped I/O decode.

## Interface
- MAX_WAIT, 4: consecutive denied cycles after which port 1 is forced to win (fixed-priority mode only); legal range 1..15
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this grant
- addr0 / addr1  in  8  data address
- wdata0 / wdata1  in  8  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse
- rdata0 / rdata1  out  8  read data, held between pulses
- mem_rdEn, mem_wrEn  out  1  memory enables
- mem_addr  out  8  memory address
- mem_wrData  out  8  memory write data
- mem_rdData  in  8  memory read data, valid cycle after mem_rdEn

## Operation
- Winner selection per cycle, in order: (1) a locked owner with req high wins exclusively; (2) if owner exists but its req is low, nobody is granted; (3) if both request: fixed mode picks port 0 unless wait1 ≥ MAX_WAIT; RR mode picks the port not granted last; (4) single requester wins.
- Granted port's we/addr/wdata drive mem_*; mem_rdEn = gnt & ~we, mem_wrEn = gnt & we. No grant: enables 0, mem_addr/mem_wrData 0.
- Owner register: set to granted port when its lock=1; cleared in any cycle the owner's lock=0.
- wait1 counter: increments (saturating at 15) each cycle req1 high and gnt1 low; cleared on gnt1 or req1 low.
- last register: updated to granted port on every grant.
- Read return: rd_owner registered on read grant; next cycle rvalidN pulses for that port and rdataN <= mem_rdData. Write grants produce no rvalid.
- Dropping req before grant is legal; no state changes for that port except wait1 clear.

## Timing
- Grant: same cycle as winning req. Read latency: rvalid exactly 1 cycle after gnt. Back-to-back grants to either port every cycle allowed; rvalid pipelines one per cycle.
- Reset values: gnt0/1 0, rvalid0/1 0, rdata0/1 0x00, mem enables 0, owner none, last = port 1 (port 0 wins first RR tie), wait1 0, rd_owner none.
- Reset mid-read: pending rvalid dropped; no pulse after reset release.
- Simultaneous lock release and other-port request: release takes effect next cycle; other port granted no earlier than cycle after owner's lock=0.

## Configuration
- ARB_RR_EN defined: round-robin tie break via last; wait1 and MAX_WAIT unused (counter not built).
- Not defined: fixed priority port 0 with wait1 starvation override.

## Structure
- Package data_mem_arb_pkg: port-id enum (PORT_CPU=0, PORT_DBG=1, PORT_NONE), ADDR_W=8, DATA_W=8, WAIT_W=4.
- One sub-module: arb_pick (combinational winner selection from req, owner, last, wait1); state and return path in top.

## Test plan
- req0 read addr 0x10 (mem holds 0x5A), req1 idle -> gnt0 cycle N, rvalid0 and rdata0=0x5A cycle N+1, rvalid1 stays 0.
- Both request continuously, fixed mode, MAX_WAIT=4 -> gnt0 four cycles, gnt1 fifth cycle, pattern repeats.
- Both request, ARB_RR_EN -> grants alternate 0,1,0,1 starting with port 0 after reset.
- Port 1 writes 0x33 to 0x20 with lock1=1 for 3 grants while req0 high -> gnt0 held 0 until cycle after lock1=0, then gnt0.
- Port 0 read granted cycle N, reset asserted cycle N+1 -> rvalid0 0, rdata0 0x00, all outputs at reset values.
- Owner port 1 locked with req1 low, req0 high -> no grant, mem enables 0, until lock1 drops.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and widths for the data memory arbiter (CPU port 0, debug/loader port 1).
package data_mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;

  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  typedef enum logic [1:0] {
    PORT_CPU  = 2'd0,
    PORT_DBG  = 2'd1,
    PORT_NONE = 2'd2
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// Combinational winner selection for the data memory arbiter.
// ARB_RR_EN selects round-robin tie break; otherwise fixed priority with starvation override.
module arb_pick
  import data_mem_arb_pkg::*;
`ifndef ARB_RR_EN
#(
  parameter int MAX_WAIT = 4
)
`endif
(
  input  logic              req0,
  input  logic              req1,
  input  port_e             owner,
`ifdef ARB_RR_EN
  input  port_e             last,
`else
  input  logic [WAIT_W-1:0] wait1,
`endif
  output port_e             winner
);

`ifndef ARB_RR_EN
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
`endif

  always_comb begin
    // NOTE: default first so every path assigns winner and no latch is inferred.
    winner = PORT_NONE;
    if (owner != PORT_NONE) begin
      // A locked owner keeps the memory even while idle; the other port waits.
      if ((owner == PORT_CPU && req0) || (owner == PORT_DBG && req1)) begin
        winner = owner;
      end
    end else if (req0 && req1) begin
`ifdef ARB_RR_EN
      winner = other_port(last);
`else
      winner = (wait1 >= MAX_WAIT_V) ? PORT_DBG : PORT_CPU;
`endif
    end else if (req0) begin
      winner = PORT_CPU;
    end else if (req1) begin
      winner = PORT_DBG;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory, with registered-read return path.
// Define ARB_RR_EN for round-robin tie break; default is fixed priority to port 0.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  input  logic [DATA_W-1:0] mem_rdData
);

  port_e             owner_q, owner_d;
  port_e             rd_owner_q, rd_owner_d;
  port_e             winner;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              req0_v, req1_v;

`ifdef ARB_RR_EN
  port_e             last_q, last_d;
`else
  logic [WAIT_W-1:0] wait1_q, wait1_d;
`endif

  // Nothing may be granted while reset is held, even if requests stay high.
  assign req0_v = req0 & ~reset;
  assign req1_v = req1 & ~reset;

`ifdef ARB_RR_EN
  arb_pick u_pick (
    .req0   (req0_v),
    .req1   (req1_v),
    .owner  (owner_q),
    .last   (last_q),
    .winner (winner)
  );
`else
  arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .req0   (req0_v),
    .req1   (req1_v),
    .owner  (owner_q),
    .wait1  (wait1_q),
    .winner (winner)
  );
`endif

  always_comb begin
    gnt0       = (winner == PORT_CPU);
    gnt1       = (winner == PORT_DBG);
    mem_rdEn   = 1'b0;
    mem_wrEn   = 1'b0;
    mem_addr   = '0;
    mem_wrData = '0;
    case (winner)
      PORT_CPU: begin
        mem_rdEn   = ~we0;
        mem_wrEn   = we0;
        mem_addr   = addr0;
        mem_wrData = wdata0;
      end
      PORT_DBG: begin
        mem_rdEn   = ~we1;
        mem_wrEn   = we1;
        mem_addr   = addr1;
        mem_wrData = wdata1;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    // Release wins over a fresh lock: the owner's lock=0 frees the memory next cycle.
    if ((owner_q == PORT_CPU && !lock0) || (owner_q == PORT_DBG && !lock1)) begin
      owner_d = PORT_NONE;
    end else if (winner == PORT_CPU && lock0) begin
      owner_d = PORT_CPU;
    end else if (winner == PORT_DBG && lock1) begin
      owner_d = PORT_DBG;
    end
    rd_owner_d = mem_rdEn ? winner : PORT_NONE;
`ifdef ARB_RR_EN
    last_d = (winner != PORT_NONE) ? winner : last_q;
`else
    wait1_d = '0;
    if (req1 && !gnt1) begin
      wait1_d = (wait1_q == WAIT_SAT) ? wait1_q : wait1_q + 1'b1;
    end
`endif
  end

  // Read data flows straight through on the pulse cycle, then is held.
  always_comb begin
    rvalid0 = (rd_owner_q == PORT_CPU);
    rvalid1 = (rd_owner_q == PORT_DBG);
    rdata0  = rvalid0 ? mem_rdData : rdata0_q;
    rdata1  = rvalid1 ? mem_rdData : rdata1_q;
  end

  assign rdata0_d = rdata0;
  assign rdata1_d = rdata1;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= PORT_NONE;
      rd_owner_q <= PORT_NONE;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef ARB_RR_EN
      last_q     <= PORT_DBG;
`else
      wait1_q    <= '0;
`endif
    end else begin
      owner_q    <= owner_d;
      rd_owner_q <= rd_owner_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifdef ARB_RR_EN
      last_q     <= last_d;
`else
      wait1_q    <= wait1_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner cases, random vs model.
module tb_data_mem_arbiter;

  localparam int MAX_WAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_rdEn, mem_wrEn;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wrData, mem_rdData;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem      [256];
  logic [7:0] init_img [256];
  logic       load_img = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .lock0      (lock0),
    .lock1      (lock1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .mem_rdEn   (mem_rdEn),
    .mem_wrEn   (mem_wrEn),
    .mem_addr   (mem_addr),
    .mem_wrData (mem_wrData),
    .mem_rdData (mem_rdData)
  );

  // Single-port memory with registered read.
  always @(posedge clk) begin
    if (load_img) begin
      mem <= init_img;
    end else begin
      if (mem_wrEn) mem[mem_addr] <= mem_wrData;
      if (mem_rdEn) mem_rdData <= mem[mem_addr];
    end
  end

  // Reference model state.
  int         m_owner, m_last, m_wait, m_rd_port;
  logic [7:0] m_pend;
  logic [7:0] m_rdata [2];
  logic [7:0] ref_mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 1;
    m_wait    = 0;
    m_rd_port = -1;
    m_pend    = 8'h00;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
  endtask

  function automatic int ref_pick(input logic [1:0] rq);
    if (m_owner >= 0) return rq[m_owner] ? m_owner : -1;
    if (rq == 2'b11) begin
`ifdef ARB_RR_EN
      return 1 - m_last;
`else
      return (m_wait >= MAX_WAIT) ? 1 : 0;
`endif
    end
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  // Compare the DUT against the model for the current inputs, then advance the model one clock.
  task automatic model_cycle(input string tag);
    logic [1:0] rq, wq, lk;
    logic [7:0] ad [2];
    logic [7:0] wd [2];
    logic [7:0] e_rd [2];
    logic [5:0] e_ctl;
    logic [7:0] e_addr, e_wdat;
    logic       e_rd_en, e_wr_en;
    int         w;
    rq = {req1, req0};
    wq = {we1, we0};
    lk = {lock1, lock0};
    ad[0] = addr0;  ad[1] = addr1;
    wd[0] = wdata0; wd[1] = wdata1;
    w = ref_pick(rq);
    e_rd[0] = m_rdata[0];
    e_rd[1] = m_rdata[1];
    if (m_rd_port >= 0) e_rd[m_rd_port] = m_pend;
    e_addr  = (w >= 0) ? ad[w] : 8'h00;
    e_wdat  = (w >= 0) ? wd[w] : 8'h00;
    e_rd_en = (w >= 0) ? ~wq[w] : 1'b0;
    e_wr_en = (w >= 0) ?  wq[w] : 1'b0;
    e_ctl   = {w == 0, w == 1, e_rd_en, e_wr_en, m_rd_port == 0, m_rd_port == 1};
    check({tag, " model ctl"}, 32'({gnt0, gnt1, mem_rdEn, mem_wrEn, rvalid0, rvalid1}), 32'(e_ctl));
    check({tag, " model mem_addr"}, 32'(mem_addr), 32'(e_addr));
    check({tag, " model mem_wrData"}, 32'(mem_wrData), 32'(e_wdat));
    check({tag, " model rdata"}, 32'({rdata0, rdata1}), 32'({e_rd[0], e_rd[1]}));
    if (m_rd_port >= 0) m_rdata[m_rd_port] = m_pend;
    m_rd_port = -1;
    if (w >= 0) begin
      if (wq[w]) ref_mem[ad[w]] = wd[w];
      else begin
        m_rd_port = w;
        m_pend    = ref_mem[ad[w]];
      end
      m_last = w;
    end
    if (w == 1 || !rq[1]) m_wait = 0;
    else if (m_wait < 15) m_wait++;
    if (m_owner >= 0 && !lk[m_owner]) m_owner = -1;
    else if (w >= 0 && lk[w]) m_owner = w;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic l0, input logic l1, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  // Called at a falling edge after driving; checks {gnt0,gnt1,rdEn,wrEn} and the model.
  task automatic step_chk(input string name, input logic [3:0] exp);
    #1;
    check(name, 32'({gnt0, gnt1, mem_rdEn, mem_wrEn}), 32'(exp));
    model_cycle(name);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       r0, r1, w0, w1, l0, l1;
    logic [7:0] a0, a1, d0, d1;
    logic [5:0] ctl;   // {gnt0, gnt1, mem_rdEn, mem_wrEn, rvalid0, rvalid1}
    logic [7:0] addr;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [1:0] exp_g;

    // Vectors from reset; no two-way ties, so expectations hold in either arbitration mode.
    vecs[0] = '{0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 6'b000000, 8'h00, 8'h00,8'h00};
    vecs[1] = '{1,0,0,0,0,0, 8'h10,8'h00,8'h00,8'h00, 6'b101000, 8'h10, 8'h00,8'h00};
    vecs[2] = '{0,1,0,0,0,0, 8'h00,8'h30,8'h00,8'h00, 6'b011010, 8'h30, 8'h5A,8'h00};
    vecs[3] = '{0,1,0,1,0,0, 8'h00,8'h20,8'h00,8'h33, 6'b010101, 8'h20, 8'h5A,8'hC3};
    vecs[4] = '{1,0,1,0,1,0, 8'h40,8'h00,8'h77,8'h00, 6'b100100, 8'h40, 8'h5A,8'hC3};
    vecs[5] = '{1,1,0,0,1,0, 8'h20,8'h30,8'h00,8'h00, 6'b101000, 8'h20, 8'h5A,8'hC3};
    vecs[6] = '{0,1,0,0,1,0, 8'h00,8'h30,8'h00,8'h00, 6'b000010, 8'h00, 8'h33,8'hC3};
    vecs[7] = '{0,1,0,0,0,0, 8'h00,8'h30,8'h00,8'h00, 6'b000000, 8'h00, 8'h33,8'hC3};
    vecs[8] = '{0,1,0,0,0,0, 8'h00,8'h40,8'h00,8'h00, 6'b011000, 8'h40, 8'h33,8'hC3};
    vecs[9] = '{0,0,0,0,0,0, 8'h00,8'h00,8'h00,8'h00, 6'b000001, 8'h00, 8'h33,8'h77};

    for (int i = 0; i < 256; i++) init_img[i] = 8'($urandom);
    init_img[8'h10] = 8'h5A;
    init_img[8'h30] = 8'hC3;
    init_img[8'h20] = 8'h00;
    init_img[8'h40] = 8'h00;
    ref_mem = init_img;

    idle();
    reset    = 1'b1;
    load_img = 1'b1;
    repeat (2) @(negedge clk);
    load_img = 1'b0;
    reset    = 1'b0;
    model_reset();

    #1;
    check("reset ctl", 32'({gnt0, gnt1, mem_rdEn, mem_wrEn, rvalid0, rvalid1}), 32'(0));
    check("reset rdata", 32'({rdata0, rdata1}), 32'(0));
    check("reset mem bus", 32'({mem_addr, mem_wrData}), 32'(0));
    model_cycle("post-reset");
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].l0, vecs[i].l1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      check($sformatf("vec%0d ctl", i),
            32'({gnt0, gnt1, mem_rdEn, mem_wrEn, rvalid0, rvalid1}), 32'(vecs[i].ctl));
      check($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d rdata0", i), 32'(rdata0), 32'(vecs[i].rd0));
      check($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(vecs[i].rd1));
      model_cycle($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Both ports requesting reads every cycle from reset.
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), 8'(8'h80 + i), 8'h00, 8'h00);
`ifdef ARB_RR_EN
      exp_g = (i % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
`endif
      step_chk($sformatf("tie%0d", i), {exp_g, 2'b10});
    end

    // Port 1 locked writes, then idle while still owning, then release.
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00, 8'h33);
    step_chk("lock grant1", 4'b0101);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00, 8'h33);
    step_chk("lock grant2", 4'b0101);
    step_chk("lock grant3", 4'b0101);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h20, 8'h00, 8'h33);
    step_chk("owner idle a", 4'b0000);
    step_chk("owner idle b", 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h20, 8'h00, 8'h33);
    step_chk("lock release", 4'b0000);
    step_chk("after release", 4'b1010);
    idle();
    #1;
    check("locked write data", 32'({rvalid0, rdata0}), 32'({1'b1, 8'h33}));
    model_cycle("locked write readback");
    @(negedge clk);

    // Reset lands on the cycle a port 0 read would return.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00);
    step_chk("rst_mid gnt", 4'b1010);
    reset = 1'b1;
    #1;
    check("rst_mid ctl", 32'({gnt0, gnt1, mem_rdEn, mem_wrEn, rvalid0, rvalid1}), 32'(0));
    check("rst_mid rdata", 32'({rdata0, rdata1}), 32'(0));
    check("rst_mid mem bus", 32'({mem_addr, mem_wrData}), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rst_mid after%0d", i), 32'({rvalid0, rdata0}), 32'(0));
      model_cycle("rst_mid after");
      @(negedge clk);
    end

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom));
      #1;
      model_cycle($sformatf("rand%0d", i));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
